// File: rtl/rr_scoreboard_pkg.sv
// Shared codes for the register-read issue scoreboard.
// FSM encodings and register-index constants.
package rr_scoreboard_pkg;

    typedef enum logic {
        SB_RUN   = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

    localparam int SB_REG_AW = 5;

    localparam logic [SB_REG_AW-1:0] SB_X0 = '0;

endpackage

// File: rtl/rr_scoreboard_issue.sv
// One-entry valid/ready issue register for rr_scoreboard.
// Loads on accept, holds while stalled, clears on consume or flush.
module rr_issue_reg
    import rr_scoreboard_pkg::*;
#(
    parameter int TAG_W  = 32,
    parameter int REG_AW = SB_REG_AW
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              load,
    input  logic              iss_ready,
    input  logic [REG_AW-1:0] d_rs1,
    input  logic [REG_AW-1:0] d_rs2,
    input  logic [REG_AW-1:0] d_rd,
    input  logic              d_wr_rd,
    input  logic [TAG_W-1:0]  d_tag,
    output logic              iss_valid,
    output logic [REG_AW-1:0] iss_rs1,
    output logic [REG_AW-1:0] iss_rs2,
    output logic [REG_AW-1:0] iss_rd,
    output logic              iss_wr_rd,
    output logic [TAG_W-1:0]  iss_tag
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid <= 1'b0;
            iss_rs1   <= '0;
            iss_rs2   <= '0;
            iss_rd    <= '0;
            iss_wr_rd <= 1'b0;
            iss_tag   <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (load) begin
            iss_valid <= 1'b1;
            iss_rs1   <= d_rs1;
            iss_rs2   <= d_rs2;
            iss_rd    <= d_rd;
            iss_wr_rd <= d_wr_rd;
            iss_tag   <= d_tag;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rr_scoreboard.sv
// Issue controller: busy scoreboard, RAW/WAW stall, fence drain.
// Optional RR_SB_PERF_EN adds stall_cycles/fence_cycles counters.
module rr_scoreboard
    import rr_scoreboard_pkg::*;
#(
    parameter int TAG_W  = 32,
    parameter int REG_AW = SB_REG_AW
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [REG_AW-1:0]    dec_rs1,
    input  logic [REG_AW-1:0]    dec_rs2,
    input  logic [REG_AW-1:0]    dec_rd,
    input  logic                 dec_use_rs1,
    input  logic                 dec_use_rs2,
    input  logic                 dec_wr_rd,
    input  logic                 dec_fence,
    input  logic [TAG_W-1:0]     dec_tag,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [REG_AW-1:0]    iss_rs1,
    output logic [REG_AW-1:0]    iss_rs2,
    output logic [REG_AW-1:0]    iss_rd,
    output logic                 iss_wr_rd,
    output logic [TAG_W-1:0]     iss_tag,
    input  logic                 wb_valid,
    input  logic [REG_AW-1:0]    wb_rd,
    output logic [2**REG_AW-1:0] busy_mask
`ifdef RR_SB_PERF_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          fence_cycles
`endif
);

    localparam int NREG = 2**REG_AW;

    sb_state_e         state;
    logic [NREG-1:0]   busy_eff;
    logic [NREG-1:0]   busy_nxt;
    logic              hazard;
    logic              out_free;
    logic              acc_fence;
    logic              acc_plain;
    logic              accept;

    // A writeback landing this cycle already frees its register.
    always_comb begin
        busy_eff = busy_mask;
        if (wb_valid) busy_eff[wb_rd] = 1'b0;
    end

    assign hazard = (dec_use_rs1 & busy_eff[dec_rs1])
                  | (dec_use_rs2 & busy_eff[dec_rs2])
                  | (dec_wr_rd   & busy_eff[dec_rd]);

    assign out_free  = !iss_valid | iss_ready;
    assign acc_fence = dec_valid & dec_fence & (busy_eff == '0)
                     & out_free & !flush;
    assign acc_plain = dec_valid & !dec_fence & !hazard & out_free
                     & !flush & (state == SB_RUN);
    assign accept    = acc_fence | acc_plain;
    assign dec_ready = accept;

    always_comb begin
        busy_nxt = busy_eff;
        if (accept && dec_wr_rd && dec_rd != SB_X0[REG_AW-1:0])
            busy_nxt[dec_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_mask <= '0;
        end else if (flush) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= SB_RUN;
        end else if (flush) begin
            state <= SB_RUN;
        end else begin
            case (state)
                SB_RUN:
                    if (dec_valid && dec_fence && !acc_fence)
                        state <= SB_DRAIN;
                SB_DRAIN:
                    if (acc_fence) state <= SB_RUN;
                default: state <= SB_RUN;
            endcase
        end
    end

    rr_issue_reg #(
        .TAG_W  (TAG_W),
        .REG_AW (REG_AW)
    ) u_issue (
        .clock     (clock),
        .reset_n   (reset_n),
        .flush     (flush),
        .load      (accept),
        .iss_ready (iss_ready),
        .d_rs1     (dec_rs1),
        .d_rs2     (dec_rs2),
        .d_rd      (dec_rd),
        .d_wr_rd   (dec_wr_rd),
        .d_tag     (dec_tag),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_wr_rd (iss_wr_rd),
        .iss_tag   (iss_tag)
    );

`ifdef RR_SB_PERF_EN
    // Counters survive flush so they measure whole-run behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            fence_cycles <= '0;
        end else begin
            if (dec_valid && !dec_ready && !flush)
                stall_cycles <= stall_cycles + 32'd1;
            if (state == SB_DRAIN)
                fence_cycles <= fence_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rr_scoreboard.sv
// Directed self-checking bench for rr_scoreboard.
module tb_rr_scoreboard;

    localparam int TAG_W  = 32;
    localparam int REG_AW = 5;

    logic              clock;
    logic              reset_n;
    logic              flush;
    logic              dec_valid;
    logic              dec_ready;
    logic [REG_AW-1:0] dec_rs1;
    logic [REG_AW-1:0] dec_rs2;
    logic [REG_AW-1:0] dec_rd;
    logic              dec_use_rs1;
    logic              dec_use_rs2;
    logic              dec_wr_rd;
    logic              dec_fence;
    logic [TAG_W-1:0]  dec_tag;
    logic              iss_valid;
    logic              iss_ready;
    logic [REG_AW-1:0] iss_rs1;
    logic [REG_AW-1:0] iss_rs2;
    logic [REG_AW-1:0] iss_rd;
    logic              iss_wr_rd;
    logic [TAG_W-1:0]  iss_tag;
    logic              wb_valid;
    logic [REG_AW-1:0] wb_rd;
    logic [31:0]       busy_mask;
`ifdef RR_SB_PERF_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       fence_cycles;
`endif

    int checks = 0;
    int errors = 0;

    rr_scoreboard #(.TAG_W(TAG_W), .REG_AW(REG_AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_use_rs1 (dec_use_rs1),
        .dec_use_rs2 (dec_use_rs2),
        .dec_wr_rd   (dec_wr_rd),
        .dec_fence   (dec_fence),
        .dec_tag     (dec_tag),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .iss_rs1     (iss_rs1),
        .iss_rs2     (iss_rs2),
        .iss_rd      (iss_rd),
        .iss_wr_rd   (iss_wr_rd),
        .iss_tag     (iss_tag),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .busy_mask   (busy_mask)
`ifdef RR_SB_PERF_EN
        ,
        .stall_cycles(stall_cycles),
        .fence_cycles(fence_cycles)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic u1,
                         input logic u2, input logic w, input logic f,
                         input logic [31:0] tag);
        dec_valid   = 1'b1;
        dec_rs1     = rs1;
        dec_rs2     = rs2;
        dec_rd      = rd;
        dec_use_rs1 = u1;
        dec_use_rs2 = u2;
        dec_wr_rd   = w;
        dec_fence   = f;
        dec_tag     = tag;
    endtask

    task automatic idle();
        dec_valid   = 1'b0;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wr_rd   = 1'b0;
        dec_fence   = 1'b0;
    endtask

    task automatic wb(input logic v, input logic [4:0] r);
        wb_valid = v;
        wb_rd    = r;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        iss_ready = 1'b0;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_rd    = '0;
        dec_tag   = '0;
        idle();
        wb(1'b0, 5'd0);
        #3;
        chk("rst_busy", busy_mask, 0);
        chk("rst_valid", iss_valid, 0);
        chk("rst_tag", iss_tag, 0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // RAW stall released by same-cycle writeback
        iss_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd5, 0, 0, 1, 0, 32'h100);
        #2 chk("raw_acc0", dec_ready, 1);
        tick();
        chk("raw_tag0", iss_tag, 32'h100);
        chk("raw_busy5", busy_mask, 32'h20);
        drive(5'd5, 5'd0, 5'd6, 1, 0, 0, 0, 32'h104);
        #2 chk("raw_stall1", dec_ready, 0);
        tick();
        chk("raw_drained", iss_valid, 0);
        #2 chk("raw_stall2", dec_ready, 0);
        tick();
        wb(1'b1, 5'd5);
        #2 chk("raw_bypass", dec_ready, 1);
        tick();
        wb(1'b0, 5'd0);
        chk("raw_tag1", iss_tag, 32'h104);
        chk("raw_valid1", iss_valid, 1);
        chk("raw_busy0", busy_mask, 0);
`ifdef RR_SB_PERF_EN
        chk("perf_stall", stall_cycles, 2);
`endif

        // Output backpressure holds fields
        iss_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd6, 1, 1, 1, 0, 32'h108);
        for (int i = 0; i < 3; i++) begin
            #2 chk("bp_ready", dec_ready, 0);
            chk("bp_tag", iss_tag, 32'h104);
            tick();
        end
        iss_ready = 1'b1;
        #2 chk("bp_acc", dec_ready, 1);
        tick();
        chk("bp_tag2", iss_tag, 32'h108);
        chk("bp_rd", iss_rd, 6);
        chk("bp_busy", busy_mask, 32'h40);
        idle();
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);
        chk("bp_clear", {busy_mask, 31'd0, iss_valid}, 0);

        // Fence drain
        drive(5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 32'h200);
        tick();
        drive(5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 32'h204);
        tick();
        chk("f_busy", busy_mask, 32'h88);
        iss_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h300);
        #2 chk("f_block0", dec_ready, 0);
        tick();
        wb(1'b1, 5'd3);
        #2 chk("f_block1", dec_ready, 0);
        tick();
        wb(1'b0, 5'd0);
        chk("f_busy7", busy_mask, 32'h80);
        iss_ready = 1'b1;
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h304);
        #2 chk("f_drain_blk", dec_ready, 0);
        tick();
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 32'h300);
        wb(1'b1, 5'd7);
        #2 chk("f_acc", dec_ready, 1);
        tick();
        wb(1'b0, 5'd0);
        chk("f_tag", iss_tag, 32'h300);
        chk("f_busy0", busy_mask, 0);
        drive(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 32'h304);
        #2 chk("f_run", dec_ready, 1);
        tick();
        chk("f_tag2", iss_tag, 32'h304);

        // Set beats same-cycle writeback; x0 never busy
        drive(5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 32'h400);
        wb(1'b1, 5'd9);
        #2 chk("sw_acc", dec_ready, 1);
        tick();
        wb(1'b0, 5'd0);
        chk("sw_busy9", busy_mask, 32'h200);
        drive(5'd0, 5'd0, 5'd0, 1, 0, 1, 0, 32'h404);
        #2 chk("x0_acc", dec_ready, 1);
        tick();
        chk("x0_busy", busy_mask, 32'h200);

        // Flush clears tracking
        drive(5'd0, 5'd0, 5'd8, 0, 0, 1, 0, 32'h500);
        tick();
        drive(5'd0, 5'd0, 5'd10, 0, 0, 1, 0, 32'h504);
        tick();
        drive(5'd0, 5'd0, 5'd11, 0, 0, 1, 0, 32'h508);
        tick();
        chk("fl_busy", busy_mask, 32'hF00);
        chk("fl_valid", iss_valid, 1);
        iss_ready = 1'b0;
        drive(5'd0, 5'd0, 5'd12, 0, 0, 1, 0, 32'h50C);
        flush = 1'b1;
        #2 chk("fl_noacc", dec_ready, 0);
        tick();
        flush = 1'b0;
        idle();
        chk("fl_busy0", busy_mask, 0);
        chk("fl_valid0", iss_valid, 0);

        // Asynchronous reset mid-run
        drive(5'd0, 5'd0, 5'd4, 0, 0, 1, 0, 32'h600);
        tick();
        idle();
        chk("ar_busy", busy_mask, 32'h10);
        chk("ar_valid", iss_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_busy0", busy_mask, 0);
        chk("ar_valid0", iss_valid, 0);
        chk("ar_tag0", iss_tag, 0);
        chk("ar_rd0", iss_rd, 0);
        tick();
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
